// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port. Master 0 (load/store unit)
// normally wins. Master 1 (debug/DMA) is forced a grant after losing
// STARVE_LIMIT grants in a row to master 0. One transaction is in flight at a
// time: the fire cycle drives the memory, and the next cycle returns the response.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_we,
    input  logic [3:0]        m0_req_be,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [31:0]       m0_req_wdata,
    output logic              m0_rsp_valid,
    output logic [31:0]       m0_rsp_rdata,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_we,
    input  logic [3:0]        m1_req_be,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [31:0]       m1_req_wdata,
    output logic              m1_rsp_valid,
    output logic [31:0]       m1_rsp_rdata,

    output logic              mem_read_enable,
    output logic [3:0]        mem_write_byte_select,
    output logic [3:0]        mem_read_byte_select,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic {
        StIdle,
        StResp
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;      // 0 = master 0, 1 = master 1
    logic        owner_we_q, owner_we_d;
    logic [7:0]  starve_q, starve_d;

    logic              grant_m1;
    logic              accept;
    logic              fire;
    logic              sel_we;
    logic [3:0]        sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              rsp_active;
    logic [31:0]       rsp_data;

    // Arbitration, request handshake and memory drive for the fire cycle.
    always_comb begin
        grant_m1 = m1_req_valid && (!m0_req_valid || (32'(starve_q) >= STARVE_LIMIT));
        // rst gating keeps ready low even before the asynchronous reset settles state.
        accept   = rst && (state_q == StIdle);

        m0_req_ready = accept && m0_req_valid && !grant_m1;
        m1_req_ready = accept && grant_m1;
        fire         = m0_req_ready || m1_req_ready;

        sel_we    = grant_m1 ? m1_req_we    : m0_req_we;
        sel_be    = grant_m1 ? m1_req_be    : m0_req_be;
        sel_addr  = grant_m1 ? m1_req_addr  : m0_req_addr;
        sel_wdata = grant_m1 ? m1_req_wdata : m0_req_wdata;

        mem_read_enable       = 1'b0;
        mem_write_byte_select = 4'b0000;
        mem_read_byte_select  = 4'b0000;
        mem_address           = '0;
        mem_data_in           = 32'h0;
        if (fire) begin
            mem_address = sel_addr;
            if (sel_we) begin
                mem_write_byte_select = sel_be;
                mem_data_in           = sel_wdata;
            end else begin
                mem_read_enable      = 1'b1;
                mem_read_byte_select = sel_be;
            end
        end
    end

    // Next-state: IDLE -> RESP on fire, RESP always back to IDLE; starvation count.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_we_d = owner_we_q;
        starve_d   = starve_q;

        unique case (state_q)
            StIdle: begin
                if (fire) begin
                    state_d    = StResp;
                    owner_d    = grant_m1;
                    owner_we_d = sel_we;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (m1_req_ready) begin
            starve_d = 8'd0;
        end else if (m0_req_ready && m1_req_valid && (starve_q != 8'hFF)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // Response routing to the registered owner; writes return zero data.
    always_comb begin
        rsp_active   = (state_q == StResp);
        rsp_data     = owner_we_q ? 32'h0 : mem_data_out;
        m0_rsp_valid = rsp_active && !owner_q;
        m1_rsp_valid = rsp_active && owner_q;
        m0_rsp_rdata = m0_rsp_valid ? rsp_data : 32'h0;
        m1_rsp_rdata = m1_rsp_valid ? rsp_data : 32'h0;
    end

    // State registers; an in-flight response is dropped on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            owner_we_q <= 1'b0;
            starve_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_we_q <= owner_we_d;
            starve_q   <= starve_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a memory stub, a transaction-level
// reference model compared on every negative edge, and directed scenarios
// with hand-computed literal expectations.
module tb_dmem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [3:0]  m0_req_be;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic        m0_rsp_valid;
    logic [31:0] m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we;
    logic [3:0]  m1_req_be;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic        m1_rsp_valid;
    logic [31:0] m1_rsp_rdata;
    logic        mem_read_enable;
    logic [3:0]  mem_write_byte_select, mem_read_byte_select;
    logic [31:0] mem_address, mem_data_in, mem_data_out;

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .ADDR_W       (32)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .m0_req_valid          (m0_req_valid),
        .m0_req_ready          (m0_req_ready),
        .m0_req_we             (m0_req_we),
        .m0_req_be             (m0_req_be),
        .m0_req_addr           (m0_req_addr),
        .m0_req_wdata          (m0_req_wdata),
        .m0_rsp_valid          (m0_rsp_valid),
        .m0_rsp_rdata          (m0_rsp_rdata),
        .m1_req_valid          (m1_req_valid),
        .m1_req_ready          (m1_req_ready),
        .m1_req_we             (m1_req_we),
        .m1_req_be             (m1_req_be),
        .m1_req_addr           (m1_req_addr),
        .m1_req_wdata          (m1_req_wdata),
        .m1_rsp_valid          (m1_rsp_valid),
        .m1_rsp_rdata          (m1_rsp_rdata),
        .mem_read_enable       (mem_read_enable),
        .mem_write_byte_select (mem_write_byte_select),
        .mem_read_byte_select  (mem_read_byte_select),
        .mem_address           (mem_address),
        .mem_data_in           (mem_data_in),
        .mem_data_out          (mem_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 4 KB memory stub with one-cycle registered read.
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4] = 32'h12345678;
        mem_data_out = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_read_enable) mem_data_out <= mem[mem_address[11:2]];
            for (int b = 0; b < 4; b++)
                if (mem_write_byte_select[b]) mem[mem_address[11:2]][8*b +: 8] <= mem_data_in[8*b +: 8];
        end
    end

    // Reference model: pending-response queue, starvation count, shadow memory.
    typedef struct {
        bit          owner;
        logic [31:0] data;
    } rsp_t;

    rsp_t        pend[$];
    int          grant_log[$];   // DUT grants as observed: 0 or 1
    logic [31:0] shadow [0:1023];

    initial begin
        int   starve;
        bit   f, g, we;
        logic [3:0]  be;
        logic [31:0] addr, wd, word;
        rsp_t r;
        starve = 0;
        for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;
        shadow[4] = 32'h12345678;
        forever begin
            @(negedge clk);
            if (m0_req_ready) grant_log.push_back(0);
            if (m1_req_ready) grant_log.push_back(1);
            if (!rst) begin
                pend.delete();
                starve = 0;
                chk("rst_m0_ready", {31'b0, m0_req_ready}, 32'h0);
                chk("rst_m1_ready", {31'b0, m1_req_ready}, 32'h0);
                chk("rst_m0_rsp", {31'b0, m0_rsp_valid}, 32'h0);
                chk("rst_m1_rsp", {31'b0, m1_rsp_valid}, 32'h0);
                chk("rst_mem_re", {31'b0, mem_read_enable}, 32'h0);
                chk("rst_mem_wbs", {28'b0, mem_write_byte_select}, 32'h0);
                chk("rst_mem_addr", mem_address, 32'h0);
            end else if (pend.size() != 0) begin
                r = pend.pop_front();
                chk("resp_m0_ready", {31'b0, m0_req_ready}, 32'h0);
                chk("resp_m1_ready", {31'b0, m1_req_ready}, 32'h0);
                chk("resp_m0_valid", {31'b0, m0_rsp_valid}, {31'b0, !r.owner});
                chk("resp_m1_valid", {31'b0, m1_rsp_valid}, {31'b0, r.owner});
                chk("resp_m0_rdata", m0_rsp_rdata, r.owner ? 32'h0 : r.data);
                chk("resp_m1_rdata", m1_rsp_rdata, r.owner ? r.data : 32'h0);
                chk("resp_mem_re", {31'b0, mem_read_enable}, 32'h0);
                chk("resp_mem_wbs", {28'b0, mem_write_byte_select}, 32'h0);
                chk("resp_mem_addr", mem_address, 32'h0);
            end else begin
                f = 1'b1;
                if (m0_req_valid && !(m1_req_valid && starve >= int'(LIMIT))) g = 1'b0;
                else if (m1_req_valid) g = 1'b1;
                else f = 1'b0;
                chk("idle_m0_ready", {31'b0, m0_req_ready}, {31'b0, f && !g});
                chk("idle_m1_ready", {31'b0, m1_req_ready}, {31'b0, f && g});
                chk("idle_m0_rsp", {31'b0, m0_rsp_valid}, 32'h0);
                chk("idle_m1_rsp", {31'b0, m1_rsp_valid}, 32'h0);
                we   = g ? m1_req_we : m0_req_we;
                be   = g ? m1_req_be : m0_req_be;
                addr = g ? m1_req_addr : m0_req_addr;
                wd   = g ? m1_req_wdata : m0_req_wdata;
                chk("mem_re", {31'b0, mem_read_enable}, {31'b0, f && !we});
                chk("mem_rbs", {28'b0, mem_read_byte_select}, (f && !we) ? {28'b0, be} : 32'h0);
                chk("mem_wbs", {28'b0, mem_write_byte_select}, (f && we) ? {28'b0, be} : 32'h0);
                chk("mem_addr", mem_address, f ? addr : 32'h0);
                chk("mem_din", mem_data_in, (f && we) ? wd : 32'h0);
                if (f) begin
                    if (g) starve = 0;
                    else if (m1_req_valid && starve < 255) starve++;
                    word = shadow[addr[11:2]];
                    r.owner = g;
                    r.data  = we ? 32'h0 : word;
                    if (we)
                        for (int b = 0; b < 4; b++)
                            if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
                    shadow[addr[11:2]] = word;
                    pend.push_back(r);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input bit v, input bit we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d);
        m0_req_valid = v; m0_req_we = we; m0_req_be = be; m0_req_addr = a; m0_req_wdata = d;
    endtask

    task automatic req1(input bit v, input bit we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d);
        m1_req_valid = v; m1_req_we = we; m1_req_be = be; m1_req_addr = a; m1_req_wdata = d;
    endtask

    initial begin
        int base;
        int seen;
        int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        rst = 1'b0;
        req0(0, 0, 4'h0, 32'h0, 32'h0);
        req1(0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        @(negedge clk);
        chk("lit_reset_ready", {31'b0, m0_req_ready}, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // m0 read 0x10 -> 0x12345678 one cycle later
        req0(1, 0, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk("lit_t1_ready", {31'b0, m0_req_ready}, 32'h1);
        chk("lit_t1_re", {31'b0, mem_read_enable}, 32'h1);
        chk("lit_t1_addr", mem_address, 32'h10);
        tick();
        req0(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_t1_rsp", {31'b0, m0_rsp_valid}, 32'h1);
        chk("lit_t1_rdata", m0_rsp_rdata, 32'h12345678);
        chk("lit_t1_m1rsp", {31'b0, m1_rsp_valid}, 32'h0);
        tick();

        // m1 partial write then read back
        req1(1, 1, 4'b0011, 32'h20, 32'hAABBCCDD);
        tick();
        req1(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_t2_wrsp", {31'b0, m1_rsp_valid}, 32'h1);
        chk("lit_t2_wdata", m1_rsp_rdata, 32'h0);
        tick();
        req1(1, 0, 4'h0, 32'h20, 32'h0);
        tick();
        req1(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_t2_rdata", m1_rsp_rdata, 32'h0000CCDD);
        tick();

        // Continuous contention: m0 x4 then m1, repeating
        base = grant_log.size();
        req0(1, 0, 4'h0, 32'h10, 32'h0);
        req1(1, 0, 4'h0, 32'h20, 32'h0);
        repeat (20) tick();
        req0(0, 0, 4'h0, 32'h0, 32'h0);
        req1(0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("lit_t3_count", grant_log.size() - base, 32'd10);
        for (int i = 0; i < 10; i++)
            if (base + i < grant_log.size())
                chk($sformatf("lit_t3_grant%0d", i), grant_log[base+i], exp_seq[i]);

        // Reset during the response cycle of an m0 read
        req0(1, 0, 4'h0, 32'h10, 32'h0);
        tick();
        req0(0, 0, 4'h0, 32'h0, 32'h0);
        req1(1, 0, 4'h0, 32'h10, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_t4_rsp", {31'b0, m0_rsp_valid}, 32'h0);
        chk("lit_t4_ready", {31'b0, m1_req_ready}, 32'h0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("lit_t4_m1fire", {31'b0, m1_req_ready}, 32'h1);
        tick();
        req1(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_t4_m1rsp", m1_rsp_rdata, 32'h12345678);
        tick();

        // m1 write with no byte enables
        req1(1, 1, 4'b0000, 32'h30, 32'hFFFFFFFF);
        @(negedge clk);
        chk("lit_t5_ready", {31'b0, m1_req_ready}, 32'h1);
        chk("lit_t5_wbs", {28'b0, mem_write_byte_select}, 32'h0);
        tick();
        req1(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_t5_rsp", {31'b0, m1_rsp_valid}, 32'h1);
        chk("lit_t5_rdata", m1_rsp_rdata, 32'h0);
        tick();
        @(negedge clk);
        chk("lit_t5_once", {31'b0, m1_rsp_valid}, 32'h0);
        tick();

        // m1 gains priority; m0 withdraws while waiting
        req0(1, 0, 4'h0, 32'h10, 32'h0);
        req1(1, 0, 4'h0, 32'h20, 32'h0);
        repeat (8) tick();
        @(negedge clk);
        chk("lit_t6_m0_ready", {31'b0, m0_req_ready}, 32'h0);
        chk("lit_t6_m1_ready", {31'b0, m1_req_ready}, 32'h1);
        tick();
        req0(0, 0, 4'h0, 32'h0, 32'h0);
        req1(0, 0, 4'h0, 32'h0, 32'h0);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (m0_rsp_valid || m0_req_ready) seen++;
            tick();
        end
        chk("lit_t6_no_m0", seen, 32'd0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
